// File: rtl/pipelined_vector_alu_pkg.sv
// Shared types and per-element arithmetic for the pipelined vector ALU.
// Element helpers are width-generic; callers pass a constant element width.
package pipelined_vector_alu_pkg;

    localparam int VEC_LANE_WIDTH = 32;
    localparam int VEC_WORD_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_ADDS  = 3'd2,
        OP_ADDUS = 3'd3,
        OP_SUBUS = 3'd4,
        OP_MIN   = 3'd5,
        OP_MAX   = 3'd6,
        OP_MAXU  = 3'd7
    } vec_alu_op_e;

    typedef enum logic [1:0] {
        ES_8    = 2'd0,
        ES_16   = 2'd1,
        ES_32   = 2'd2,
        ES_RSVD = 2'd3
    } vec_elem_size_e;

    typedef struct packed {
        logic                      sat;
        logic [VEC_LANE_WIDTH-1:0] res;
    } elem_result_t;

    // One n-bit element; a and b carry the element zero-extended in their low n bits.
    // The result comes back in the low n bits with everything above cleared.
    function automatic elem_result_t elem_op(
        input vec_alu_op_e op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [5:0]  n
    );
        logic [31:0]        mask;
        logic [4:0]         msb;
        logic [33:0]        span;
        logic [33:0]        ua;
        logic [33:0]        ub;
        logic [33:0]        usum;
        logic [33:0]        udiff;
        logic signed [33:0] sa;
        logic signed [33:0] sb;
        logic signed [33:0] ssum;
        logic signed [33:0] smax;
        logic signed [33:0] smin;
        elem_result_t       r;

        mask  = (32'd1 << n) - 32'd1;
        msb   = 5'(n - 6'd1);
        span  = 34'd1 << n;
        ua    = {2'b00, a & mask};
        ub    = {2'b00, b & mask};
        sa    = a[msb] ? $signed(ua - span) : $signed(ua);
        sb    = b[msb] ? $signed(ub - span) : $signed(ub);
        smax  = $signed((span >> 1) - 34'd1);
        smin  = -smax - 34'sd1;
        usum  = ua + ub;
        udiff = ua - ub;
        ssum  = sa + sb;

        r = '0;
        case (op)
            OP_ADD: r.res = usum[31:0] & mask;
            OP_SUB: r.res = udiff[31:0] & mask;
            OP_ADDS: begin
                if (ssum > smax) begin
                    r.res = smax[31:0] & mask;
                    r.sat = 1'b1;
                end else if (ssum < smin) begin
                    r.res = smin[31:0] & mask;
                    r.sat = 1'b1;
                end else begin
                    r.res = ssum[31:0] & mask;
                end
            end
            OP_ADDUS: begin
                if (usum > {2'b00, mask}) begin
                    r.res = mask;
                    r.sat = 1'b1;
                end else begin
                    r.res = usum[31:0];
                end
            end
            OP_SUBUS: begin
                if (ua < ub) begin
                    r.res = '0;
                    r.sat = 1'b1;
                end else begin
                    r.res = udiff[31:0];
                end
            end
            OP_MIN:  r.res = (sa < sb) ? ua[31:0] : ub[31:0];
            OP_MAX:  r.res = (sa > sb) ? ua[31:0] : ub[31:0];
            OP_MAXU: r.res = (ua > ub) ? ua[31:0] : ub[31:0];
            default: r.res = usum[31:0] & mask;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vector_lane_alu.sv
// Combinational ALU for one 32-bit lane: computes all three packings in parallel
// and selects by element size, so no carry ever crosses an element boundary.
module vector_lane_alu
    import pipelined_vector_alu_pkg::*;
(
    input  logic [2:0]                i_op_code,
    input  logic [1:0]                i_elem_size,
    input  logic [VEC_LANE_WIDTH-1:0] i_op_a,
    input  logic [VEC_LANE_WIDTH-1:0] i_op_b,
    output logic [VEC_LANE_WIDTH-1:0] o_result,
    output logic                      o_sat
);

    vec_alu_op_e  w_op;
    elem_result_t w_r8  [4];
    elem_result_t w_r16 [2];
    elem_result_t w_r32;

    assign w_op = vec_alu_op_e'(i_op_code);

    for (genvar i = 0; i < 4; i++) begin : g_elem8
        assign w_r8[i] = elem_op(w_op, {24'd0, i_op_a[8*i +: 8]}, {24'd0, i_op_b[8*i +: 8]}, 6'd8);
    end

    for (genvar i = 0; i < 2; i++) begin : g_elem16
        assign w_r16[i] = elem_op(w_op, {16'd0, i_op_a[16*i +: 16]}, {16'd0, i_op_b[16*i +: 16]}, 6'd16);
    end

    assign w_r32 = elem_op(w_op, i_op_a, i_op_b, 6'd32);

    // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
    always_comb begin
        o_result = w_r32.res;
        o_sat    = w_r32.sat;
        case (vec_elem_size_e'(i_elem_size))
            ES_8: begin
                o_result = w_r8[0].res | (w_r8[1].res << 8) | (w_r8[2].res << 16) | (w_r8[3].res << 24);
                o_sat    = w_r8[0].sat | w_r8[1].sat | w_r8[2].sat | w_r8[3].sat;
            end
            ES_16: begin
                o_result = w_r16[0].res | (w_r16[1].res << 16);
                o_sat    = w_r16[0].sat | w_r16[1].sat;
            end
            default: begin
                o_result = w_r32.res;
                o_sat    = w_r32.sat;
            end
        endcase
    end

endmodule

// File: rtl/pipelined_vector_alu.sv
// Pipelined SIMD integer ALU: combinational lane ALUs feed PIPELINE_DEPTH-1
// register stages carrying {valid, data, tag, sat}, with shared stall/flush control.
module pipelined_vector_alu
    import pipelined_vector_alu_pkg::*;
#(
    parameter int LANE_COUNT     = VEC_WORD_WIDTH,
    parameter int PIPELINE_DEPTH = 3,
    parameter int TAG_WIDTH      = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                stall,
    input  logic                                flush,
    input  logic                                validIn,
    input  logic [2:0]                          opCode,
    input  logic [1:0]                          elemSize,
    input  logic [TAG_WIDTH-1:0]                tagIn,
    input  logic [VEC_LANE_WIDTH*LANE_COUNT-1:0] fuOpA_In,
    input  logic [VEC_LANE_WIDTH*LANE_COUNT-1:0] fuOpB_In,
    output logic                                validOut,
    output logic [VEC_LANE_WIDTH*LANE_COUNT-1:0] dataOut,
    output logic [TAG_WIDTH-1:0]                tagOut,
    output logic                                satFlag,
    output logic                                busy
);

    localparam int DW   = VEC_LANE_WIDTH * LANE_COUNT;
    localparam int NSTG = PIPELINE_DEPTH - 1;

    logic [DW-1:0]         w_data;
    logic [LANE_COUNT-1:0] w_lane_sat;
    logic                  w_sat;
    logic                  w_accept;

    logic [NSTG-1:0]       r_valid;
    logic [NSTG-1:0]       r_sat;
    logic [DW-1:0]         r_data [NSTG];
    logic [TAG_WIDTH-1:0]  r_tag  [NSTG];

    for (genvar l = 0; l < LANE_COUNT; l++) begin : g_lane
        vector_lane_alu u_lane (
            .i_op_code   (opCode),
            .i_elem_size (elemSize),
            .i_op_a      (fuOpA_In[VEC_LANE_WIDTH*l +: VEC_LANE_WIDTH]),
            .i_op_b      (fuOpB_In[VEC_LANE_WIDTH*l +: VEC_LANE_WIDTH]),
            .o_result    (w_data[VEC_LANE_WIDTH*l +: VEC_LANE_WIDTH]),
            .o_sat       (w_lane_sat[l])
        );
    end

    assign w_sat    = |w_lane_sat;
    assign w_accept = validIn & ~stall & ~flush;

    // NOTE: non-blocking assignments let every stage sample the previous stage's old value in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data/tag/sat are reset too, because reset must drive every output to zero.
            r_valid <= '0;
            r_sat   <= '0;
            for (int s = 0; s < NSTG; s++) begin
                r_data[s] <= '0;
                r_tag[s]  <= '0;
            end
        end else begin
            if (flush) begin
                r_valid <= '0;
            end else if (!stall) begin
                r_valid[0] <= w_accept;
                for (int s = 1; s < NSTG; s++) begin
                    r_valid[s] <= r_valid[s-1];
                end
            end

            // Payload moves regardless of valid; a flush freezes it like a stall.
            if (!stall && !flush) begin
                r_data[0] <= w_data;
                r_tag[0]  <= tagIn;
                r_sat[0]  <= w_sat;
                for (int s = 1; s < NSTG; s++) begin
                    r_data[s] <= r_data[s-1];
                    r_tag[s]  <= r_tag[s-1];
                    r_sat[s]  <= r_sat[s-1];
                end
            end
        end
    end

    assign validOut = r_valid[NSTG-1];
    assign dataOut  = r_data[NSTG-1];
    assign tagOut   = r_tag[NSTG-1];
    assign satFlag  = r_sat[NSTG-1];
    assign busy     = |r_valid;

endmodule

// File: tb/tb_pipelined_vector_alu.sv
// Self-checking bench: directed spec vectors, stall/flush/reset sequences and a
// randomised scoreboard run against an independent integer reference model.
module tb_pipelined_vector_alu;
    import pipelined_vector_alu_pkg::*;

    localparam int LANES = 4;
    localparam int DEPTH = 3;
    localparam int TW    = 8;
    localparam int DW    = 32 * LANES;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, stall, flush, validIn;
    logic [2:0]    opCode;
    logic [1:0]    elemSize;
    logic [TW-1:0] tagIn;
    logic [DW-1:0] fuOpA_In, fuOpB_In;
    logic          validOut, satFlag, busy;
    logic [DW-1:0] dataOut;
    logic [TW-1:0] tagOut;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic [2:0]    r_op;
    logic [1:0]    r_es;
    logic [DW-1:0] r_a, r_b, r_exp;
    logic          r_sat;
    int unsigned   pick;

    always #5 clk = ~clk;

    pipelined_vector_alu #(
        .LANE_COUNT     (LANES),
        .PIPELINE_DEPTH (DEPTH),
        .TAG_WIDTH      (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .validIn  (validIn),
        .opCode   (opCode),
        .elemSize (elemSize),
        .tagIn    (tagIn),
        .fuOpA_In (fuOpA_In),
        .fuOpB_In (fuOpB_In),
        .validOut (validOut),
        .dataOut  (dataOut),
        .tagOut   (tagOut),
        .satFlag  (satFlag),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: elements handled as plain 64-bit integers.
    function automatic void model_lane(input logic [2:0] op, input logic [1:0] es,
                                       input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] res, output logic sat);
        int     n;
        longint mask, half, ua, ub, sa, sb, r;
        n    = (es == 2'd0) ? 8 : (es == 2'd1) ? 16 : 32;
        mask = (longint'(1) << n) - 1;
        half = longint'(1) << (n - 1);
        res  = '0;
        sat  = 1'b0;
        for (int e = 0; e < 32 / n; e++) begin
            ua = (longint'(a) >> (e * n)) & mask;
            ub = (longint'(b) >> (e * n)) & mask;
            sa = (ua >= half) ? ua - (mask + 1) : ua;
            sb = (ub >= half) ? ub - (mask + 1) : ub;
            case (op)
                3'd0: r = ua + ub;
                3'd1: r = ua - ub;
                3'd2: begin
                    r = sa + sb;
                    if (r > half - 1) begin r = half - 1; sat = 1'b1; end
                    else if (r < -half) begin r = -half; sat = 1'b1; end
                end
                3'd3: begin r = ua + ub; if (r > mask) begin r = mask; sat = 1'b1; end end
                3'd4: begin r = ua - ub; if (r < 0) begin r = 0; sat = 1'b1; end end
                3'd5: r = (sa <= sb) ? ua : ub;
                3'd6: r = (sa >= sb) ? ua : ub;
                default: r = (ua >= ub) ? ua : ub;
            endcase
            res = res | (32'(r & mask) << (e * n));
        end
    endfunction

    task automatic model_vec(input logic [2:0] op, input logic [1:0] es,
                             input logic [DW-1:0] a, input logic [DW-1:0] b,
                             output logic [DW-1:0] res, output logic sat);
        logic [31:0] lr;
        logic        ls;
        sat = 1'b0;
        res = '0;
        for (int l = 0; l < LANES; l++) begin
            model_lane(op, es, a[32*l +: 32], b[32*l +: 32], lr, ls);
            res[32*l +: 32] = lr;
            sat = sat | ls;
        end
    endtask

    // Presents one op for one cycle; returns 1 time unit after the capturing edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] es, input logic [TW-1:0] tag,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] exp_data, input logic exp_sat);
        opCode   = op;
        elemSize = es;
        tagIn    = tag;
        fuOpA_In = a;
        fuOpB_In = b;
        validIn  = 1'b1;
        if (!stall && !flush && !rst) sb.push_back('{data: exp_data, tag: tag, sat: exp_sat});
        @(posedge clk);
        #1;
        validIn = 1'b0;
    endtask

    task automatic issue_rep(input logic [2:0] op, input logic [1:0] es, input logic [TW-1:0] tag,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_lane, input logic exp_sat);
        issue(op, es, tag, {LANES{a}}, {LANES{b}}, {LANES{exp_lane}}, exp_sat);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        #1;
        check("drain_timeout", DW'(sb.size()), '0);
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_valid"}, DW'(validOut), '0);
        check({pfx, "_data"},  dataOut,       '0);
        check({pfx, "_tag"},   DW'(tagOut),   '0);
        check({pfx, "_sat"},   DW'(satFlag),  '0);
        check({pfx, "_busy"},  DW'(busy),     '0);
    endtask

    // Output is consumed on an edge that is neither stalled, flushed nor reset.
    always @(negedge clk) begin
        if (!rst && !stall && !flush && validOut) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", DW'(validOut), '0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_data", dataOut,       mon_e.data);
                check("sb_tag",  DW'(tagOut),   DW'(mon_e.tag));
                check("sb_sat",  DW'(satFlag),  DW'(mon_e.sat));
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; validIn = 1'b0;
        opCode = '0; elemSize = '0; tagIn = '0; fuOpA_In = '0; fuOpB_In = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Lane-wise wrap add plus latency of DEPTH-1 cycles.
        issue_rep(3'd0, 2'd2, 8'h11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
        check("lat_early_valid", DW'(validOut), '0);
        check("lat_early_busy",  DW'(busy),     DW'(1));
        @(posedge clk);
        #1;
        check("lat_valid", DW'(validOut), DW'(1));

        // Directed element-size and saturation vectors, back to back.
        issue_rep(3'd2, 2'd0, 8'h12, 32'h7F80_0102, 32'h01FF_0101, 32'h7F80_0203, 1'b1);
        issue_rep(3'd4, 2'd1, 8'h13, 32'h0001_0005, 32'h0002_0003, 32'h0000_0002, 1'b1);
        issue_rep(3'd5, 2'd1, 8'h14, 32'h8000_0001, 32'h7FFF_0002, 32'h8000_0001, 1'b0);
        issue_rep(3'd7, 2'd1, 8'h15, 32'h8000_0001, 32'h7FFF_0002, 32'h8000_0002, 1'b0);
        issue_rep(3'd3, 2'd3, 8'h16, 32'hFFFF_FFF0, 32'h0000_0020, 32'hFFFF_FFFF, 1'b1);
        issue_rep(3'd1, 2'd0, 8'h17, 32'h0000_0000, 32'h0101_0101, 32'hFFFF_FFFF, 1'b0);
        issue_rep(3'd6, 2'd0, 8'h18, 32'h80FF_7F00, 32'h7F00_0180, 32'h7F00_7F00, 1'b0);
        issue_rep(3'd2, 2'd2, 8'h19, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
        issue_rep(3'd0, 2'd1, 8'h1A, 32'hFFFF_0001, 32'h0001_0001, 32'h0000_0002, 1'b0);
        issue_rep(3'd2, 2'd1, 8'h1B, 32'h8000_8000, 32'hFFFF_0001, 32'h8000_8001, 1'b1);
        wait_drain();

        // Back-to-back with a 2-cycle stall while tag 1 sits in the last stage (depth 3).
        issue_rep(3'd0, 2'd0, 8'd1, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 1'b0);
        issue_rep(3'd0, 2'd0, 8'd2, 32'h0202_0202, 32'h0202_0202, 32'h0404_0404, 1'b0);
        check("pre_stall_valid", DW'(validOut), DW'(1));
        check("pre_stall_tag",   DW'(tagOut),   DW'(1));
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", DW'(validOut), DW'(1));
            check("stall_tag",   DW'(tagOut),   DW'(1));
            check("stall_data",  dataOut,       {LANES{32'h0303_0303}});
        end
        stall = 1'b0;
        issue_rep(3'd0, 2'd0, 8'd3, 32'h0303_0303, 32'h0202_0202, 32'h0505_0505, 1'b0);
        check("b2b_tag2", DW'(tagOut), DW'(2));
        @(posedge clk);
        #1;
        check("b2b_tag3",  DW'(tagOut), DW'(3));
        check("b2b_busy3", DW'(busy),   DW'(1));
        @(posedge clk);
        #1;
        check("b2b_done_valid", DW'(validOut), '0);
        check("b2b_done_busy",  DW'(busy),     '0);

        // Flush with stall and a new op present: everything in flight dies.
        issue_rep(3'd0, 2'd2, 8'h40, 32'h0000_0010, 32'h0000_0001, 32'h0000_0011, 1'b0);
        issue_rep(3'd0, 2'd2, 8'h41, 32'h0000_0020, 32'h0000_0001, 32'h0000_0021, 1'b0);
        stall = 1'b1; flush = 1'b1; validIn = 1'b1; tagIn = 8'h42;
        sb.delete();
        @(posedge clk);
        #1;
        stall = 1'b0; flush = 1'b0; validIn = 1'b0;
        check("flush_valid",    DW'(validOut), '0);
        check("flush_busy",     DW'(busy),     '0);
        check("flush_tag_hold", DW'(tagOut),   DW'(8'h40));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("flush_quiet", DW'(validOut), '0);
        end

        // Reset mid-operation overrides an op on the inputs.
        issue_rep(3'd3, 2'd0, 8'h50, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0);
        rst = 1'b1; validIn = 1'b1; tagIn = 8'h51;
        sb.delete();
        @(posedge clk);
        #1;
        check_zero_outputs("mid_reset");
        rst = 1'b0; validIn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_quiet", DW'(validOut), '0);
        end

        // Random ops with idle and stall bubbles, checked against the model.
        for (int k = 0; k < 80; k++) begin
            pick = $urandom_range(0, 9);
            if (pick < 7) begin
                r_op = 3'($urandom_range(0, 7));
                r_es = 2'($urandom_range(0, 3));
                for (int l = 0; l < LANES; l++) begin
                    r_a[32*l +: 32] = $urandom();
                    r_b[32*l +: 32] = (pick == 0) ? r_a[32*l +: 32] ^ 32'h8080_8080 : $urandom();
                end
                model_vec(r_op, r_es, r_a, r_b, r_exp, r_sat);
                issue(r_op, r_es, TW'(k), r_a, r_b, r_exp, r_sat);
            end else if (pick < 8) begin
                stall = 1'b1;
                @(posedge clk);
                #1;
                stall = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();
        @(posedge clk);
        #1;
        check("final_busy", DW'(busy), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
